// File: rtl/board_io_ctrl.sv
// Board user-I/O controller.
// Synchronizes and debounces the five push buttons, synchronizes the eight DIP
// switches, and drives the eight user LEDs from a three-mode state machine:
// design status with heartbeat, switch echo, or a walking-one lamp test.
//
// Ports:
//   clk        single clock for all logic
//   rstn       asynchronous active-low reset
//   btn_raw    raw buttons {btnc, btnr, btnd, btnl, btnu}, asynchronous
//   sw_raw     raw DIP switches, asynchronous
//   status     design status bits, synchronous to clk
//   btn_level  debounced button levels
//   btn_press  one-cycle pulse on each debounced rising edge
//   sw_sync    synchronized switch values
//   mode       current LED mode (0 status, 1 switch, 2 walk)
//   led        registered LED drive

module board_io_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned HEARTBEAT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] btn_raw,
  input  logic [7:0] sw_raw,
  input  logic [7:0] status,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [7:0] sw_sync,
  output logic [1:0] mode,
  output logic [7:0] led
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HbW = $clog2(HEARTBEAT_CYCLES);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HbW-1:0] HbLast = HbW'(HEARTBEAT_CYCLES - 1);

  localparam int unsigned BtnL = 1;
  localparam int unsigned BtnR = 3;
  localparam int unsigned BtnC = 4;

  typedef enum logic [1:0] {
    StStatus  = 2'd0,
    StSwitch  = 2'd1,
    StWalk    = 2'd2,
    StInvalid = 2'd3
  } mode_e;

  mode_e state_q, state_d;

  logic [4:0]          btn_s1_q, btn_s2_q;
  logic [7:0]          sw_s1_q, sw_s2_q;
  logic [4:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [4:0]          level_q, level_d;
  logic [4:0]          press_q, press_d;
  logic [HbW-1:0]      tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                heartbeat_q, heartbeat_d;
  logic [7:0]          walk_q, walk_d;
  logic                dir_left_q, dir_left_d;
  logic [7:0]          led_q, led_d;

  // status[7] is replaced by the heartbeat in status mode.
  logic unused_status;
  assign unused_status = status[7];

  // Debounce: a counter runs while the synchronized input disagrees with the
  // accepted level; any agreeing cycle restarts it.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (btn_s2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Registered alongside level so the pulse lines up with the first high cycle.
  assign press_d = level_d & ~level_q;

  assign tick        = (tick_cnt_q == HbLast);
  assign tick_cnt_d  = tick ? '0 : tick_cnt_q + HbW'(1);
  assign heartbeat_d = heartbeat_q ^ tick;

  // Mode FSM: state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StStatus;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStatus: if (press_q[BtnC]) state_d = StSwitch;
      StSwitch: if (press_q[BtnC]) state_d = StWalk;
      StWalk:   if (press_q[BtnC]) state_d = StStatus;
      default:  state_d = StStatus;
    endcase
  end

  // Walk direction and pattern. Rotation uses the direction held before this
  // edge; entering walk mode reloads the pattern ahead of any rotation.
  always_comb begin
    dir_left_d = dir_left_q;
    if (press_q[BtnL] && !press_q[BtnR]) begin
      dir_left_d = 1'b1;
    end else if (press_q[BtnR] && !press_q[BtnL]) begin
      dir_left_d = 1'b0;
    end

    walk_d = walk_q;
    if ((state_d == StWalk) && (state_q != StWalk)) begin
      walk_d = 8'h01;
    end else if (tick && (state_q == StWalk)) begin
      walk_d = dir_left_q ? {walk_q[6:0], walk_q[7]} : {walk_q[0], walk_q[7:1]};
    end
  end

  // Mode FSM: outputs.
  always_comb begin
    led_d = 8'h00;
    case (state_q)
      StStatus: led_d = {heartbeat_q, status[6:0]};
      StSwitch: led_d = sw_s2_q;
      StWalk:   led_d = walk_q;
      default:  led_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      db_cnt_q    <= '0;
      level_q     <= '0;
      press_q     <= '0;
      tick_cnt_q  <= '0;
      heartbeat_q <= 1'b0;
      walk_q      <= 8'h01;
      dir_left_q  <= 1'b1;
      led_q       <= 8'h00;
    end else begin
      btn_s1_q    <= btn_raw;
      btn_s2_q    <= btn_s1_q;
      sw_s1_q     <= sw_raw;
      sw_s2_q     <= sw_s1_q;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      tick_cnt_q  <= tick_cnt_d;
      heartbeat_q <= heartbeat_d;
      walk_q      <= walk_d;
      dir_left_q  <= dir_left_d;
      led_q       <= led_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign sw_sync   = sw_s2_q;
  assign mode      = state_q;
  assign led       = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Testbench for board_io_ctrl with DEBOUNCE_CYCLES = 4, HEARTBEAT_CYCLES = 8.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.

module tb_board_io_ctrl;

  logic       clk;
  logic       rstn;
  logic [4:0] btn_raw;
  logic [7:0] sw_raw;
  logic [7:0] status;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [7:0] sw_sync;
  logic [1:0] mode;
  logic [7:0] led;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;  // edges since reset release; tick falls in cycles where cyc % 8 == 7

  typedef struct packed {
    logic [7:0] sw;
    logic [7:0] exp_sw;
    logic [7:0] exp_led;
  } vec_t;

  vec_t       vecs [18];
  logic [7:0] left_seq  [8];
  logic [7:0] right_seq [3];
  logic [7:0] both_seq  [2];
  logic [7:0] lback_seq [2];

  board_io_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HEARTBEAT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .status   (status),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .sw_sync  (sw_sync),
    .mode     (mode),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Hold the buttons until the debounced press shows (6th edge, counting the
  // first sampling edge as 1), check the pulse, then release. Returns in the
  // press cycle.
  task automatic do_press(input logic [4:0] mask);
    btn_raw = mask;
    step_n(6);
    check("press_pulse", 16'(btn_press), 16'(mask));
    btn_raw = 5'h00;
  endtask

  task automatic align(input int r);
    for (int k = 0; k < 8 && (cyc % 8) != r; k++) step();
  endtask

  // Stop in a tick cycle, then move to where the led shows its effect.
  task automatic tick_then_led();
    align(7);
    step_n(2);
  endtask

  initial begin
    vecs[0]  = '{sw: 8'h3C, exp_sw: 8'h00, exp_led: 8'h55};
    vecs[1]  = '{sw: 8'hC3, exp_sw: 8'h3C, exp_led: 8'h55};
    vecs[2]  = '{sw: 8'hC3, exp_sw: 8'hC3, exp_led: 8'h55};
    vecs[3]  = '{sw: 8'h00, exp_sw: 8'hC3, exp_led: 8'h55};
    vecs[4]  = '{sw: 8'hFF, exp_sw: 8'h00, exp_led: 8'h55};
    vecs[5]  = '{sw: 8'h81, exp_sw: 8'hFF, exp_led: 8'h55};
    vecs[6]  = '{sw: 8'hA3, exp_sw: 8'h81, exp_led: 8'h55};
    vecs[7]  = '{sw: 8'hA3, exp_sw: 8'hA3, exp_led: 8'h55};
    for (int i = 8; i < 16; i++) vecs[i] = '{sw: 8'hA3, exp_sw: 8'hA3, exp_led: 8'hD5};
    vecs[16] = '{sw: 8'hA3, exp_sw: 8'hA3, exp_led: 8'h55};
    vecs[17] = '{sw: 8'hA3, exp_sw: 8'hA3, exp_led: 8'h55};

    left_seq  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    right_seq = '{8'h01, 8'h80, 8'h40};
    both_seq  = '{8'h10, 8'h08};
    lback_seq = '{8'h08, 8'h10};

    // Reset with random inputs.
    rstn    = 1'b0;
    btn_raw = 5'($urandom);
    sw_raw  = 8'($urandom);
    status  = 8'($urandom);
    step_n(3);
    check("rst_btn_level", 16'(btn_level), 16'h0);
    check("rst_btn_press", 16'(btn_press), 16'h0);
    check("rst_sw_sync",   16'(sw_sync),   16'h0);
    check("rst_mode",      16'(mode),      16'h0);
    check("rst_led",       16'(led),       16'h0);

    btn_raw = 5'h00;
    sw_raw  = 8'h00;
    status  = 8'h55;
    rstn    = 1'b1;

    // Switch synchronizer latency and heartbeat in status mode.
    for (int i = 0; i < 18; i++) begin
      sw_raw = vecs[i].sw;
      step();
      check("vec_sw_sync", 16'(sw_sync), 16'(vecs[i].exp_sw));
      check("vec_led",     16'(led),     16'(vecs[i].exp_led));
    end

    // Bounce rejection: 3-cycle highs never reach 4 stable synchronized cycles.
    for (int r = 0; r < 5; r++) begin
      btn_raw[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        check("bounce_level", 16'(btn_level), 16'h0);
        check("bounce_press", 16'(btn_press), 16'h0);
      end
      btn_raw[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        check("bounce_level", 16'(btn_level), 16'h0);
        check("bounce_press", 16'(btn_press), 16'h0);
      end
    end

    // Stable high: level rises on the 6th edge, single press pulse.
    btn_raw[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      check("hold_level0", 16'(btn_level[0]), (n >= 6) ? 16'h1 : 16'h0);
      check("hold_press0", 16'(btn_press[0]), (n == 6) ? 16'h1 : 16'h0);
    end
    // Release: no pulse.
    btn_raw[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      check("release_press", 16'(btn_press), 16'h0);
    end
    check("release_level", 16'(btn_level), 16'h0);

    // Mode cycling with sw_raw = 0xA3.
    do_press(5'h10);
    step(); check("cyc1_mode", 16'(mode), 16'h1);
    step(); check("cyc1_led",  16'(led),  16'hA3);
    step_n(6);
    do_press(5'h10);
    step(); check("cyc2_mode", 16'(mode), 16'h2);
    step(); check("cyc2_led",  16'(led),  16'h01);
    step_n(6);
    do_press(5'h10);
    step(); check("cyc3_mode", 16'(mode), 16'h0);
    step(); check("cyc3_led_status", 16'(led & 8'h7F), 16'h55);
    step_n(6);

    // Into SWITCH, then enter WALK with the press coincident with a tick.
    do_press(5'h10);
    step(); check("sw_mode", 16'(mode), 16'h1);
    step_n(6);
    align(1);
    do_press(5'h10);
    step(); check("bnd_mode", 16'(mode), 16'h2);
    step(); check("bnd_led",  16'(led),  16'h01);

    // Walk left through a full wrap.
    for (int k = 0; k < 8; k++) begin
      tick_then_led();
      check("walk_left", 16'(led), 16'(left_seq[k]));
    end

    // btnr pressed in a tick cycle: that rotation still goes left (0x01->0x02),
    // later ticks go right.
    do_press(5'h08);
    step_n(2);
    check("walk_r_coinc", 16'(led), 16'h02);
    check("walk_r_mode",  16'(mode), 16'h2);
    for (int k = 0; k < 3; k++) begin
      tick_then_led();
      check("walk_right", 16'(led), 16'(right_seq[k]));
    end

    // btnl+btnr together: direction stays right.
    do_press(5'h0A);
    step_n(2);
    check("walk_both_coinc", 16'(led), 16'h20);
    for (int k = 0; k < 2; k++) begin
      tick_then_led();
      check("walk_both", 16'(led), 16'(both_seq[k]));
    end

    // btnl in a tick cycle: rotation right once more, then left.
    do_press(5'h02);
    step_n(2);
    check("walk_l_coinc", 16'(led), 16'h04);
    for (int k = 0; k < 2; k++) begin
      tick_then_led();
      check("walk_left_back", 16'(led), 16'(lback_seq[k]));
    end

    // Asynchronous reset mid-walk (led = 0x10).
    rstn = 1'b0;
    #1;
    check("midrst_mode",  16'(mode),      16'h0);
    check("midrst_led",   16'(led),       16'h0);
    check("midrst_level", 16'(btn_level), 16'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    check("postrst_led", 16'(led), 16'h55);
    do_press(5'h10);
    step(); check("postrst_mode1", 16'(mode), 16'h1);
    step_n(6);
    do_press(5'h10);
    step(); check("postrst_mode2", 16'(mode), 16'h2);
    step(); check("postrst_walk",  16'(led),  16'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Board user-I/O controller for the ZCU106 top level. It synchronizes and debounces the five push buttons, and synchronizes the eight DIP switches. It drives the eight user LEDs from a mode state machine: design status with heartbeat, switch echo, or a walking-one lamp test. It sits between the board GPIO pins and the `fpga` instance, and replaces the constant LED tie-off.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button change; legal range ≥ 1.
- `HEARTBEAT_CYCLES`, default 50_000_000: period of the internal tick, in clocks; legal range ≥ 2.
- `clk`  in  1  single clock for all logic.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `btn_raw`  in  5  raw buttons, bit order {btnc, btnr, btnd, btnl, btnu} (bit 0 = btnu), active-high, asynchronous.
- `sw_raw`  in  8  raw DIP switches, asynchronous.
- `status`  in  8  design status bits, synchronous to `clk`.
- `btn_level`  out  5  debounced button levels.
- `btn_press`  out  5  one-cycle pulse per debounced 0→1 transition.
- `sw_sync`  out  8  synchronized switch values.
- `mode`  out  2  current LED mode: 0 = STATUS, 1 = SWITCH, 2 = WALK.
- `led`  out  8  LED drive, registered.

## Operation
- Synchronizers: every `btn_raw` and `sw_raw` bit passes through two flops. `sw_sync` is the second stage; the switches have no debounce.
- Debounce, per button:
  - A counter (width $clog2(DEBOUNCE_CYCLES+1)) increments on every cycle where the synchronized value ≠ `btn_level`.
  - Any cycle with a match clears the counter to 0.
  - When a mismatch cycle would bring the count to DEBOUNCE_CYCLES, `btn_level` toggles on that clock edge and the counter clears.
- `btn_press[i]` is registered. It is high for exactly one cycle, coincident with the first cycle `btn_level[i]` reads 1. Release transitions produce no pulse.
- Tick counter:
  - Free-running, counts 0..HEARTBEAT_CYCLES-1 and wraps.
  - The internal `tick` is high in the cycle the counter equals HEARTBEAT_CYCLES-1.
  - The heartbeat bit toggles on each tick.
- Mode FSM:
  - A `btn_press[4]` (btnc) advances STATUS→SWITCH→WALK→STATUS.
  - Encoding value 3 is unreachable; if it is ever present, the next cycle goes to STATUS.
- Walk direction register:
  - `btn_press[1]` (btnl) sets left (rotate toward MSB).
  - `btn_press[3]` (btnr) sets right.
  - Both pressed in the same cycle: direction is unchanged.
- Walk pattern:
  - An 8-bit one-hot register. On tick while in WALK, it rotates by one position in the current direction, with wrap: 0x80→0x01 going left, 0x01→0x80 going right.
  - Loads 0x01 on the cycle the FSM enters WALK.
- LED output (registered from current mode):
  - STATUS: `led` = {heartbeat, `status`[6:0]}.
  - SWITCH: `led` = `sw_sync`.
  - WALK: `led` = walk pattern.
- `btn_level[0]` and `btn_level[2]` (btnu, btnd) are exported only and have no internal effect.

## Timing
- Reset values: `btn_level` = 0, `btn_press` = 0, `sw_sync` = 0, `mode` = 0 (STATUS), `led` = 0. Internally: synchronizer flops 0, debounce counters 0, tick counter 0, heartbeat 0, walk = 0x01, direction = left.
- Reset asserted mid-operation returns all state to the reset values immediately. There is no glitch-free requirement on `led` during reset.
- Raw button edge held stable → `btn_level` changes DEBOUNCE_CYCLES+2 cycles after the first clock that samples the new value. A bounce shorter than DEBOUNCE_CYCLES synchronized cycles is fully rejected.
- `sw_raw` change → `sw_sync` changes 2 cycles later.
- `btn_press` at cycle N → `mode` updates at N+1 → `led` reflects the new mode at N+2.
- Tick at cycle N → heartbeat and walk update at N+1 → `led` at N+2.
- Tick coincident with a mode change into WALK: the load of 0x01 wins over rotation.
- Tick coincident with a direction change: the rotation uses the direction held before the edge.
- First tick after reset occurs at cycle HEARTBEAT_CYCLES-1.

## Test plan
(Bench parameters: DEBOUNCE_CYCLES = 4, HEARTBEAT_CYCLES = 8.)
- Reset: hold `rstn` low with random inputs → all outputs 0. Release, with `status` = 0x55 → `led` toggles between 0x55 and 0xD5 every 8 cycles.
- Bounce rejection: toggle `btn_raw[0]` high for 3 cycles, then low, repeated 5 times → `btn_level` and `btn_press` stay 0. Then hold it high → `btn_level[0]` rises 6 cycles after the first sampled high, with a single 1-cycle `btn_press[0]`.
- Mode cycling: three clean btnc presses with `sw_raw` = 0xA3:
  - 1st press → `mode` = 1 and `led` = 0xA3.
  - 2nd press → `mode` = 2 and `led` = 0x01.
  - 3rd press → `mode` = 0.
- Walk: in WALK, left direction, observe 9 ticks → `led` sequence 0x01, 0x02, …, 0x80, 0x01. Press btnr → subsequent ticks give 0x80, 0x40, … from the current position. Simultaneous btnl+btnr press → direction unchanged.
- Boundary: issue a btnc press in the same cycle as a tick while in SWITCH → `led` = 0x01 (not 0x02) two cycles later.
- Async reset mid-walk (`led` = 0x10): pulse `rstn` low for 1 cycle → `mode` = 0 and `led` = 0 during reset. After release, entering WALK again starts at 0x01.
